// File: rtl/pq_op_sequencer.sv
// rtl/pq_op_sequencer.sv - request sequencer in front of a register-array priority queue
module pq_op_sequencer #(
    parameter int DATA_WIDTH    = 16,
    parameter int CMD_DEPTH     = 4,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_op,
    input  logic [DATA_WIDTH-1:0] i_req_data,
    output logic                  o_pq_wrt,
    output logic                  o_pq_read,
    output logic [DATA_WIDTH-1:0] o_pq_data,
    input  logic                  i_pq_full,
    input  logic                  i_pq_empty,
    input  logic [DATA_WIDTH-1:0] i_pq_data,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [1:0]            o_rsp_op,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic                  o_rsp_drop,
    output logic [15:0]           o_drop_cnt
);

    localparam int AW  = $clog2(CMD_DEPTH);
    localparam int SCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [AW:0]    LP_DEPTH       = (AW+1)'(CMD_DEPTH);
    localparam logic [SCW-1:0] LP_SETTLE_LAST = SCW'(SETTLE_CYCLES - 1);

    localparam logic [1:0] OP_ENQ = 2'b00;
    localparam logic [1:0] OP_DEQ = 2'b01;
    localparam logic [1:0] OP_REP = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    logic [1:0]            r_fifo_op   [CMD_DEPTH];
    logic [DATA_WIDTH-1:0] r_fifo_data [CMD_DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [AW:0]           r_count;

    state_t                r_state;
    logic [SCW-1:0]        r_settle_cnt;
    logic                  r_pq_wrt;
    logic                  r_pq_read;
    logic [DATA_WIDTH-1:0] r_pq_data;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_op;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic                  r_rsp_drop;
    logic [15:0]           r_drop_cnt;

    logic                  w_fifo_full;
    logic                  w_fifo_empty;
    logic                  w_push;
    logic                  w_pop;
    logic [1:0]            w_head_op;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic                  w_issue;
    logic                  w_do_wrt;
    logic                  w_do_read;
    logic [1:0]            w_exec_op;

    // A full FIFO refuses new requests even when the head leaves in the same cycle.
    assign w_fifo_full  = (r_count == LP_DEPTH);
    assign w_fifo_empty = (r_count == '0);
    assign w_push       = i_req_valid && !w_fifo_full;
    assign w_pop        = (r_state == ST_IDLE) && !w_fifo_empty;
    assign w_head_op    = r_fifo_op[r_rd_ptr];
    assign w_head_data  = r_fifo_data[r_rd_ptr];

    assign o_req_ready  = !w_fifo_full;
    assign o_pq_wrt     = r_pq_wrt;
    assign o_pq_read    = r_pq_read;
    assign o_pq_data    = r_pq_data;
    assign o_rsp_valid  = r_rsp_valid;
    assign o_rsp_op     = r_rsp_op;
    assign o_rsp_data   = r_rsp_data;
    assign o_rsp_drop   = r_rsp_drop;
    assign o_drop_cnt   = r_drop_cnt;

    // Request payload storage; contents are meaningless until the count covers them.
    always_ff @(posedge CLK) begin
        if (w_push) begin
            r_fifo_op[r_wr_ptr]   <= i_req_op;
            r_fifo_data[r_wr_ptr] <= i_req_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Legality decision on the FIFO head against the queue status seen this cycle.
    always_comb begin
        w_issue   = 1'b0;
        w_do_wrt  = 1'b0;
        w_do_read = 1'b0;
        w_exec_op = w_head_op;
        case (w_head_op)
            OP_ENQ: begin
                if (!i_pq_full) begin
                    w_issue  = 1'b1;
                    w_do_wrt = 1'b1;
                end
            end
            OP_DEQ: begin
                if (!i_pq_empty) begin
                    w_issue   = 1'b1;
                    w_do_read = 1'b1;
                end
            end
            OP_REP: begin
                // Replacing into an empty queue degenerates to a plain insert.
                w_issue  = 1'b1;
                w_do_wrt = 1'b1;
                if (!i_pq_empty) w_do_read = 1'b1;
                else             w_exec_op = OP_ENQ;
            end
            default: ;
        endcase
    end

    // Sequencer FSM: issue one strobe, let the queue settle, then hold the response.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= '0;
            r_pq_wrt     <= 1'b0;
            r_pq_read    <= 1'b0;
            r_pq_data    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_op     <= '0;
            r_rsp_data   <= '0;
            r_rsp_drop   <= 1'b0;
            r_drop_cnt   <= '0;
        end else begin
            r_pq_wrt  <= 1'b0;
            r_pq_read <= 1'b0;
            r_pq_data <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_rsp_op <= w_exec_op;
                        if (w_issue) begin
                            r_pq_wrt  <= w_do_wrt;
                            r_pq_read <= w_do_read;
                            r_pq_data <= w_head_data;
                            r_state   <= ST_ISSUE;
                        end else begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_drop  <= 1'b1;
                            r_rsp_data  <= '0;
                            if (r_drop_cnt != 16'hFFFF) r_drop_cnt <= r_drop_cnt + 16'd1;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_ISSUE: begin
                    // The queue still shows the old root while the strobe is high.
                    r_rsp_data   <= r_pq_read ? i_pq_data : '0;
                    r_settle_cnt <= '0;
                    r_state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (r_settle_cnt == LP_SETTLE_LAST) begin
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (i_rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_op    <= '0;
                        r_rsp_data  <= '0;
                        r_rsp_drop  <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pq_op_sequencer.sv
// tb/tb_pq_op_sequencer.sv - self-checking bench for pq_op_sequencer with a priority queue model
module tb_pq_op_sequencer;

    localparam int DW     = 16;
    localparam int SETTLE = 1;
    localparam int QSIZE  = 8;

    logic          CLK;
    logic          RSTn;
    logic          req_valid;
    logic          o_req_ready;
    logic [1:0]    req_op;
    logic [DW-1:0] req_data;
    logic          o_pq_wrt;
    logic          o_pq_read;
    logic [DW-1:0] o_pq_data;
    logic          pq_full;
    logic          pq_empty;
    logic [DW-1:0] pq_root;
    logic          o_rsp_valid;
    logic          rsp_ready;
    logic [1:0]    o_rsp_op;
    logic [DW-1:0] o_rsp_data;
    logic          o_rsp_drop;
    logic [15:0]   o_drop_cnt;

    pq_op_sequencer #(.DATA_WIDTH(DW), .CMD_DEPTH(4), .SETTLE_CYCLES(SETTLE)) dut (
        .CLK(CLK), .RSTn(RSTn),
        .i_req_valid(req_valid), .o_req_ready(o_req_ready),
        .i_req_op(req_op), .i_req_data(req_data),
        .o_pq_wrt(o_pq_wrt), .o_pq_read(o_pq_read), .o_pq_data(o_pq_data),
        .i_pq_full(pq_full), .i_pq_empty(pq_empty), .i_pq_data(pq_root),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_op(o_rsp_op), .o_rsp_data(o_rsp_data), .o_rsp_drop(o_rsp_drop),
        .o_drop_cnt(o_drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic [1:0]    e_op;
        logic [DW-1:0] e_data;
        logic          e_drop;
    } vec_t;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] data;
        logic          drop;
    } rsp_t;

    int   n_vec = 0;
    int   n_err = 0;
    rsp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural register-array priority queue: max at the root, read removes it, write inserts.
    logic [DW-1:0] pq[$];
    int            s_cnt = 0;
    logic          last_wrt = 1'b0;
    logic          last_read = 1'b0;

    function automatic int max_idx();
        int m = 0;
        for (int i = 1; i < pq.size(); i++) if (pq[i] > pq[m]) m = i;
        return m;
    endfunction

    initial begin
        pq_full  = 1'b0;
        pq_empty = 1'b1;
        pq_root  = '0;
    end

    always @(posedge CLK) begin
        if (o_pq_wrt || o_pq_read) begin
            s_cnt++;
            last_wrt  = o_pq_wrt;
            last_read = o_pq_read;
        end
        if (o_pq_read && pq.size() > 0) pq.delete(max_idx());
        if (o_pq_wrt && pq.size() < QSIZE) pq.push_back(o_pq_data);
        pq_full  <= (pq.size() == QSIZE);
        pq_empty <= (pq.size() == 0);
        pq_root  <= (pq.size() > 0) ? pq[max_idx()] : '0;
    end

    // Response scoreboard, response stability under backpressure, strobe spacing.
    logic          prev_hold = 1'b0;
    logic [1:0]    prev_op;
    logic [DW-1:0] prev_data;
    logic          prev_drop;
    logic          prev_strobe = 1'b0;

    always @(negedge CLK) begin
        rsp_t e;
        if (prev_hold)
            chk("rsp_stable", {o_rsp_valid, o_rsp_op, o_rsp_drop, o_rsp_data},
                {1'b1, prev_op, prev_drop, prev_data});
        if (o_rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("rsp_op", 32'(o_rsp_op), 32'(e.op));
                chk("rsp_data", 32'(o_rsp_data), 32'(e.data));
                chk("rsp_drop", 32'(o_rsp_drop), 32'(e.drop));
            end
        end
        prev_hold = o_rsp_valid && !rsp_ready;
        prev_op   = o_rsp_op;
        prev_data = o_rsp_data;
        prev_drop = o_rsp_drop;
        if (o_pq_wrt || o_pq_read) chk("strobe_gap", 32'(prev_strobe), 32'd0);
        prev_strobe = o_pq_wrt || o_pq_read;
    end

    // Called at posedge+1; returns at posedge+1 just after the request was pushed.
    task automatic send(input logic [1:0] op, input logic [DW-1:0] d, input bit track,
                        input logic [1:0] e_op, input logic [DW-1:0] e_data, input logic e_drop);
        int n = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        if (track) sb.push_back('{op: e_op, data: e_data, drop: e_drop});
        @(negedge CLK);
        while (!o_req_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("req_timeout", 32'd1, 32'd0);
        @(posedge CLK);
        #1;
        req_valid = 1'b0;
    endtask

    vec_t tbl[17];

    initial begin
        int n;
        int s0;
        #1000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int s0;
        tbl[0]  = '{2'b00, 16'd5,   2'b00, 16'd0,   1'b0};
        tbl[1]  = '{2'b00, 16'd900, 2'b00, 16'd0,   1'b0};
        tbl[2]  = '{2'b00, 16'd42,  2'b00, 16'd0,   1'b0};
        tbl[3]  = '{2'b01, 16'd0,   2'b01, 16'd900, 1'b0};
        tbl[4]  = '{2'b01, 16'd0,   2'b01, 16'd42,  1'b0};
        tbl[5]  = '{2'b01, 16'd0,   2'b01, 16'd5,   1'b0};
        tbl[6]  = '{2'b01, 16'd0,   2'b01, 16'd0,   1'b1};
        tbl[7]  = '{2'b10, 16'd77,  2'b00, 16'd0,   1'b0};
        tbl[8]  = '{2'b10, 16'd10,  2'b10, 16'd77,  1'b0};
        for (int i = 0; i < 7; i++) tbl[9+i] = '{2'b00, 16'(100 + i), 2'b00, 16'd0, 1'b0};
        tbl[16] = '{2'b00, 16'd1,   2'b00, 16'd0,   1'b1};

        RSTn = 1'b0; req_valid = 1'b0; req_op = '0; req_data = '0; rsp_ready = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RSTn = 1'b1;

        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("reset_state", {o_pq_wrt, o_pq_read, o_rsp_valid, o_req_ready, o_rsp_drop},
                5'b00010);
            chk("reset_cnt", {o_drop_cnt, o_pq_data}, 32'd0);
        end
        @(posedge CLK);
        #1;

        for (int i = 0; i < 17; i++) begin
            s0 = s_cnt;
            send(tbl[i].op, tbl[i].data, 1'b1, tbl[i].e_op, tbl[i].e_data, tbl[i].e_drop);
            n = 0;
            do begin
                @(negedge CLK);
                n++;
            end while (!o_rsp_valid && n < 50);
            chk($sformatf("latency_%0d", i), 32'(n), tbl[i].e_drop ? 32'd2 : 32'(3 + SETTLE));
            @(posedge CLK);
            #1;
            chk($sformatf("drained_%0d", i), 32'(sb.size()), 32'd0);
            chk($sformatf("strobes_%0d", i), 32'(s_cnt - s0), tbl[i].e_drop ? 32'd0 : 32'd1);
            if (i == 2) chk("root_after_enq", 32'(pq_root), 32'd900);
            if (i == 6) chk("drop_cnt_deq", 32'(o_drop_cnt), 32'd1);
            if (i == 7) chk("rep_empty_strobe", {last_wrt, last_read}, 2'b10);
            if (i == 8) begin
                chk("rep_strobe", {last_wrt, last_read}, 2'b11);
                chk("root_after_rep", 32'(pq_root), 32'd10);
            end
            if (i == 15) chk("queue_full", 32'(pq_full), 32'd1);
        end

        // Backpressure: six back-to-back requests against a held response.
        rsp_ready = 1'b0;
        fork
            begin
                send(2'b01, 16'd0,   1'b1, 2'b01, 16'd106, 1'b0);
                send(2'b01, 16'd0,   1'b1, 2'b01, 16'd105, 1'b0);
                send(2'b00, 16'd3,   1'b1, 2'b00, 16'd0,   1'b0);
                send(2'b11, 16'd9,   1'b1, 2'b11, 16'd0,   1'b1);
                send(2'b10, 16'd200, 1'b1, 2'b10, 16'd104, 1'b0);
                send(2'b01, 16'd0,   1'b1, 2'b01, 16'd200, 1'b0);
            end
            begin
                n = 0;
                do begin
                    @(negedge CLK);
                    n++;
                end while (o_req_ready && n < 100);
                chk("req_ready_full", 32'(o_req_ready), 32'd0);
                chk("rsp_held", 32'(o_rsp_valid), 32'd1);
                repeat (3) @(negedge CLK);
                @(posedge CLK);
                #1 rsp_ready = 1'b1;
            end
        join
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge CLK);
            n++;
        end
        chk("bp_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge CLK);
        chk("drop_cnt_final", 32'(o_drop_cnt), 32'd3);
        @(posedge CLK);
        #1;

        // Reset while the sequencer is settling after a strobe, with a second request queued.
        send(2'b00, 16'd7, 1'b0, 2'b00, 16'd0, 1'b0);
        send(2'b00, 16'd8, 1'b0, 2'b00, 16'd0, 1'b0);
        n = 0;
        while (!o_pq_wrt && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk("issue_seen", 32'(o_pq_wrt), 32'd1);
        @(posedge CLK);
        #1 RSTn = 1'b0;
        @(posedge CLK);
        #1 RSTn = 1'b1;
        s0 = s_cnt;
        for (int c = 0; c < 10; c++) begin
            @(negedge CLK);
            chk("post_rst_state", {o_pq_wrt, o_pq_read, o_rsp_valid, o_req_ready}, 4'b0001);
        end
        chk("post_rst_strobes", 32'(s_cnt - s0), 32'd0);
        chk("post_rst_cnt", 32'(o_drop_cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
